// File: rtl/ddr3_fill_reader.sv
// Streams one fill of 128-bit DDR3 bursts from the controller's native app interface into the
// data FIFO, bounding the number of read commands whose data has not yet returned.
module ddr3_fill_reader #(
  parameter int unsigned MAX_OUTSTANDING = 32,
  parameter int unsigned ADDR_PAD        = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [22:0]  ddr3_rd_start_addr,
  input  logic [23:0]  ddr3_rd_burst_cnt,
  input  logic         enable_reading,
  output logic         reading_done,
  output logic         app_en,
  output logic [2:0]   app_cmd,
  output logic [25:0]  app_addr,
  input  logic         app_rdy,
  input  logic [127:0] app_rd_data,
  input  logic         app_rd_data_valid,
  input  logic         fifo_prog_full,
  output logic         fifo_wr_en,
  output logic [127:0] fifo_din,
  output logic         overflow_err,
  input  logic         fifo_full
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StDone, StFlush} state_e;

  state_e          state_q, state_d;
  logic [22:0]     burst_addr_q, burst_addr_d;
  logic [23:0]     cmd_left_q, cmd_left_d;
  logic [23:0]     data_left_q, data_left_d;
  logic [OutW-1:0] outstanding_q, outstanding_d;
  logic            app_en_q, app_en_d;
  logic            wr_en_q, wr_en_d;
  logic [127:0]    din_q, din_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            accept, ret;

  assign accept = app_en_q && app_rdy;
  // Returns are counted against outstanding in every state that can have requests in flight.
  assign ret    = app_rd_data_valid &&
                  (state_q == StIssue || state_q == StDrain || state_q == StFlush);

  always_comb begin
    state_d       = state_q;
    burst_addr_d  = burst_addr_q;
    cmd_left_d    = cmd_left_q;
    data_left_d   = data_left_q;
    outstanding_d = outstanding_q;
    app_en_d      = app_en_q && !app_rdy;
    wr_en_d       = 1'b0;
    din_d         = din_q;
    done_d        = done_q;
    ovf_d         = ovf_q || (app_rd_data_valid && fifo_full);

    if (accept) begin
      burst_addr_d = burst_addr_q + 23'd1;
      cmd_left_d   = cmd_left_q - 24'd1;
    end

    case ({accept, ret})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (enable_reading) begin
          burst_addr_d = ddr3_rd_start_addr;
          cmd_left_d   = ddr3_rd_burst_cnt;
          data_left_d  = ddr3_rd_burst_cnt;
          state_d      = (ddr3_rd_burst_cnt == 24'd0) ? StDone : StIssue;
        end
      end
      StIssue, StDrain: begin
        if (!enable_reading) begin
          state_d = StFlush;
        end else begin
          if (app_rd_data_valid) begin
            wr_en_d     = 1'b1;
            din_d       = app_rd_data;
            data_left_d = data_left_q - 24'd1;
          end
          if (state_q == StIssue) begin
            if (accept && cmd_left_q == 24'd1) begin
              state_d = StDrain;
            end else if ((!app_en_q || accept) && cmd_left_d != '0 &&
                         outstanding_d < OutW'(MAX_OUTSTANDING) && !fifo_prog_full) begin
              app_en_d = 1'b1;
            end
          end else if (data_left_q == 24'd0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StDone: begin
        done_d = enable_reading;
        if (!enable_reading) begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        // A raised command must finish its handshake before the count can be trusted.
        if (!app_en_q && outstanding_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      burst_addr_q  <= '0;
      cmd_left_q    <= '0;
      data_left_q   <= '0;
      outstanding_q <= '0;
      app_en_q      <= 1'b0;
      wr_en_q       <= 1'b0;
      din_q         <= '0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      burst_addr_q  <= burst_addr_d;
      cmd_left_q    <= cmd_left_d;
      data_left_q   <= data_left_d;
      outstanding_q <= outstanding_d;
      app_en_q      <= app_en_d;
      wr_en_q       <= wr_en_d;
      din_q         <= din_d;
      done_q        <= done_d;
      ovf_q         <= ovf_d;
    end
  end

  assign app_cmd      = 3'b001;
  assign app_addr     = {burst_addr_q, {ADDR_PAD{1'b0}}};
  assign app_en       = app_en_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_din     = din_q;
  assign reading_done = done_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_ddr3_fill_reader.sv
// Directed bench for ddr3_fill_reader: a latency-configurable controller responder plus
// per-scenario tasks with hand-computed expectations.
module tb_ddr3_fill_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic [22:0]  ddr3_rd_start_addr;
  logic [23:0]  ddr3_rd_burst_cnt;
  logic         enable_reading;
  logic         reading_done;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [25:0]  app_addr;
  logic         app_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         fifo_prog_full;
  logic         fifo_wr_en;
  logic [127:0] fifo_din;
  logic         overflow_err;
  logic         fifo_full;

  ddr3_fill_reader #(.MAX_OUTSTANDING(4), .ADDR_PAD(3)) dut (
    .clk               (clk),
    .reset             (reset),
    .ddr3_rd_start_addr(ddr3_rd_start_addr),
    .ddr3_rd_burst_cnt (ddr3_rd_burst_cnt),
    .enable_reading    (enable_reading),
    .reading_done      (reading_done),
    .app_en            (app_en),
    .app_cmd           (app_cmd),
    .app_addr          (app_addr),
    .app_rdy           (app_rdy),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid),
    .fifo_prog_full    (fifo_prog_full),
    .fifo_wr_en        (fifo_wr_en),
    .fifo_din          (fifo_din),
    .overflow_err      (overflow_err),
    .fifo_full         (fifo_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 10;
  bit rdy_rand = 1'b0;

  logic [25:0]  cmd_q[$];
  logic [22:0]  resp_addr[$];
  int           resp_due[$];
  logic [127:0] wr_q[$];
  int           wr_cyc[$];
  int first_en_cyc = -1, done_cyc = -1, addr_viol = 0, pf_viol = 0, out_m = 0, max_out = 0;

  logic        pf_e, acc_e, en_e, val_e;
  logic [25:0] addr_e;

  function automatic logic [127:0] exp_data(input logic [22:0] a);
    return {4{9'h155, a}};
  endfunction

  // Values as seen by the DUT at each rising edge.
  always @(posedge clk) begin
    pf_e   <= fifo_prog_full;
    acc_e  <= app_en && app_rdy;
    en_e   <= app_en;
    addr_e <= app_addr;
    val_e  <= app_rd_data_valid;
  end

  // Controller responder and output monitor, evaluated 1 time unit after each rising edge.
  initial begin
    app_rdy = 1'b0;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        resp_addr.delete();
        resp_due.delete();
        out_m = 0;
        app_rd_data_valid = 1'b0;
        app_rdy = 1'b0;
      end else begin
        if (acc_e) begin
          cmd_q.push_back(addr_e);
          resp_addr.push_back(addr_e[25:3]);
          resp_due.push_back(cyc + lat);
          out_m++;
        end
        if (val_e) out_m--;
        if (out_m > max_out) max_out = out_m;
        if (fifo_wr_en) begin
          wr_q.push_back(fifo_din);
          wr_cyc.push_back(cyc);
        end
        if (reading_done && done_cyc < 0) done_cyc = cyc;
        if (app_en && first_en_cyc < 0) first_en_cyc = cyc;
        if (app_en && (!en_e || acc_e) && pf_e) pf_viol++;
        if (en_e && !acc_e && (!app_en || app_addr != addr_e)) addr_viol++;
        app_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
          app_rd_data_valid = 1'b1;
          app_rd_data = exp_data(resp_addr.pop_front());
          void'(resp_due.pop_front());
        end else begin
          app_rd_data_valid = 1'b0;
        end
      end
    end
  end

  task automatic clear_obs();
    cmd_q.delete();
    wr_q.delete();
    wr_cyc.delete();
    first_en_cyc = -1;
    done_cyc = -1;
    addr_viol = 0;
    pf_viol = 0;
    max_out = 0;
  endtask

  task automatic start_read(input logic [22:0] a, input logic [23:0] n, output int t0);
    @(negedge clk);
    clear_obs();
    ddr3_rd_start_addr = a;
    ddr3_rd_burst_cnt = n;
    enable_reading = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (reading_done) ok = 1'b1;
    end
  endtask

  task automatic finish_read();
    @(negedge clk);
    enable_reading = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (app_en !== 1'b0) begin errors++; $display("FAIL reset_app_en: got %b want 0", app_en); end
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    checks++; if (reading_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", reading_done); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow_err); end
    checks++; if (app_addr !== 26'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", app_addr); end
    checks++; if (fifo_din !== 128'h0) begin errors++; $display("FAIL reset_din: got %h want 0", fifo_din); end
    checks++; if (app_cmd !== 3'b001) begin errors++; $display("FAIL reset_cmd: got %b want 001", app_cmd); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int t0;
    bit ok;
    logic [25:0] ea [4];
    ea[0] = 26'h800; ea[1] = 26'h808; ea[2] = 26'h810; ea[3] = 26'h818;
    lat = 10; rdy_rand = 1'b0;
    start_read(23'h000100, 24'd4, t0);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done: reading_done not seen in 200 cycles"); end
    checks++; if (first_en_cyc != t0 + 2) begin errors++; $display("FAIL basic_first_en: got cycle %0d want %0d", first_en_cyc, t0 + 2); end
    checks++; if (cmd_q.size() != 4) begin errors++; $display("FAIL basic_cmd_count: got %0d want 4", cmd_q.size()); end
    for (int i = 0; i < 4 && i < cmd_q.size(); i++) begin
      checks++; if (cmd_q[i] !== ea[i]) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", i, cmd_q[i], ea[i]); end
    end
    checks++; if (wr_q.size() != 4) begin errors++; $display("FAIL basic_wr_count: got %0d want 4", wr_q.size()); end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      checks++; if (wr_q[i] !== exp_data(23'h000100 + 23'(i))) begin errors++; $display("FAIL basic_data%0d: got %h want %h", i, wr_q[i], exp_data(23'h000100 + 23'(i))); end
    end
    checks++;
    if (wr_cyc.size() == 0 || done_cyc != wr_cyc[wr_cyc.size() - 1] + 1) begin
      errors++; $display("FAIL basic_done_latency: done at %0d, last write at %0d", done_cyc, (wr_cyc.size() == 0) ? -1 : wr_cyc[wr_cyc.size() - 1]);
    end
    finish_read();
    checks++; if (reading_done !== 1'b0) begin errors++; $display("FAIL basic_done_clear: got %b want 0", reading_done); end
  endtask

  task automatic test_wrap();
    int t0;
    bit ok;
    logic [25:0] ea [3];
    logic [22:0] eb [3];
    ea[0] = 26'h3FFFFF0; ea[1] = 26'h3FFFFF8; ea[2] = 26'h0000000;
    eb[0] = 23'h7FFFFE;  eb[1] = 23'h7FFFFF;  eb[2] = 23'h000000;
    start_read(23'h7FFFFE, 24'd3, t0);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done: reading_done not seen in 200 cycles"); end
    checks++; if (cmd_q.size() != 3) begin errors++; $display("FAIL wrap_cmd_count: got %0d want 3", cmd_q.size()); end
    for (int i = 0; i < 3 && i < cmd_q.size(); i++) begin
      checks++; if (cmd_q[i] !== ea[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, cmd_q[i], ea[i]); end
    end
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      checks++; if (wr_q[i] !== exp_data(eb[i])) begin errors++; $display("FAIL wrap_data%0d: got %h want %h", i, wr_q[i], exp_data(eb[i])); end
    end
    finish_read();
  endtask

  task automatic test_zero();
    int t0;
    bit ok;
    start_read(23'h001234, 24'd0, t0);
    wait_done(10, ok);
    checks++; if (done_cyc != t0 + 2) begin errors++; $display("FAIL zero_done_latency: got cycle %0d want %0d", done_cyc, t0 + 2); end
    checks++; if (first_en_cyc != -1) begin errors++; $display("FAIL zero_no_app_en: app_en seen at cycle %0d, want never", first_en_cyc); end
    finish_read();
    checks++; if (reading_done !== 1'b0) begin errors++; $display("FAIL zero_done_clear: got %b want 0", reading_done); end
  endtask

  task automatic test_backpressure();
    int t0, bad;
    bit ok;
    lat = 50; rdy_rand = 1'b1;
    start_read(23'h000200, 24'd64, t0);
    repeat (20) @(negedge clk);
    fifo_prog_full = 1'b1;
    repeat (40) @(negedge clk);
    fifo_prog_full = 1'b0;
    wait_done(5000, ok);
    rdy_rand = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_done: reading_done not seen in 5000 cycles"); end
    checks++; if (cmd_q.size() != 64) begin errors++; $display("FAIL bp_cmd_count: got %0d want 64", cmd_q.size()); end
    checks++; if (wr_q.size() != 64) begin errors++; $display("FAIL bp_wr_count: got %0d want 64", wr_q.size()); end
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== exp_data(23'h000200 + 23'(i))) bad++;
    for (int i = 0; i < cmd_q.size(); i++) if (cmd_q[i] !== {23'h000200 + 23'(i), 3'b000}) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_order: got %0d out-of-order entries want 0", bad); end
    checks++; if (addr_viol != 0) begin errors++; $display("FAIL bp_addr_stable: got %0d violations want 0", addr_viol); end
    checks++; if (pf_viol != 0) begin errors++; $display("FAIL bp_prog_full: got %0d new commands under prog_full want 0", pf_viol); end
    checks++; if (max_out != 4) begin errors++; $display("FAIL bp_max_outstanding: got %0d want 4", max_out); end
    finish_read();
  endtask

  task automatic test_abort();
    int t0, td, n, late_wr;
    lat = 10; rdy_rand = 1'b0;
    start_read(23'h000400, 24'd20, t0);
    n = 0;
    while (cmd_q.size() < 5 && n < 200) begin @(negedge clk); n++; end
    enable_reading = 1'b0;
    td = cyc;
    n = 0;
    while ((out_m != 0 || app_en) && n < 300) begin @(negedge clk); n++; end
    checks++; if (n >= 300) begin errors++; $display("FAIL abort_flush: outstanding=%0d app_en=%b after 300 cycles", out_m, app_en); end
    checks++; if (cmd_q.size() > 6 || cmd_q.size() < 5) begin errors++; $display("FAIL abort_cmd_count: got %0d want 5..6", cmd_q.size()); end
    late_wr = 0;
    foreach (wr_cyc[i]) if (wr_cyc[i] > td) late_wr++;
    checks++; if (late_wr != 0) begin errors++; $display("FAIL abort_no_write: got %0d writes after abort want 0", late_wr); end
    checks++; if (done_cyc != -1) begin errors++; $display("FAIL abort_no_done: reading_done at cycle %0d want never", done_cyc); end
  endtask

  task automatic test_back_to_back();
    int t0;
    bit ok;
    start_read(23'h000055, 24'd1, t0);
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done: reading_done not seen in 100 cycles"); end
    checks++; if (first_en_cyc != t0 + 2) begin errors++; $display("FAIL b2b_first_en: got cycle %0d want %0d", first_en_cyc, t0 + 2); end
    checks++; if (cmd_q.size() != 1 || cmd_q[0] !== 26'h00002A8) begin errors++; $display("FAIL b2b_addr: got %0d cmds first %h want 1 cmd 00002a8", cmd_q.size(), (cmd_q.size() > 0) ? cmd_q[0] : 26'h0); end
    checks++; if (wr_q.size() != 1 || wr_q[0] !== exp_data(23'h000055)) begin errors++; $display("FAIL b2b_data: got %0d writes want 1 with %h", wr_q.size(), exp_data(23'h000055)); end
    finish_read();
  endtask

  task automatic test_overflow_reset();
    int t0, n;
    lat = 5; rdy_rand = 1'b0;
    start_read(23'h000600, 24'd12, t0);
    fifo_full = 1'b1;
    n = 0;
    while (wr_q.size() < 1 && n < 100) begin @(negedge clk); n++; end
    fifo_full = 1'b0;
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow_err); end
    checks++; if (wr_q.size() < 1 || wr_q[0] !== exp_data(23'h000600)) begin errors++; $display("FAIL ovf_data_presented: got %0d writes want first %h", wr_q.size(), exp_data(23'h000600)); end
    repeat (3) @(negedge clk);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
    checks++; if (reading_done !== 1'b0) begin errors++; $display("FAIL ovf_mid_run: reading_done got %b want 0", reading_done); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (app_en !== 1'b0) begin errors++; $display("FAIL async_app_en: got %b want 0", app_en); end
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL async_wr_en: got %b want 0", fifo_wr_en); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL async_ovf: got %b want 0", overflow_err); end
    checks++; if (app_addr !== 26'h0) begin errors++; $display("FAIL async_addr: got %h want 0", app_addr); end
    checks++; if (fifo_din !== 128'h0) begin errors++; $display("FAIL async_din: got %h want 0", fifo_din); end
    checks++; if (reading_done !== 1'b0) begin errors++; $display("FAIL async_done: got %b want 0", reading_done); end
    enable_reading = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    ddr3_rd_start_addr = '0;
    ddr3_rd_burst_cnt = '0;
    enable_reading = 1'b0;
    fifo_prog_full = 1'b0;
    fifo_full = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_overflow_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish by time 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
